// File: rtl/execute_alu_pkg.sv
// execute_alu_pkg: shared y86 icode/ifun encodings, CC bit indices and stack constants
package execute_alu_pkg;
  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_t;
  typedef enum logic [3:0] {
    F_ADD = 4'h0,
    F_SUB = 4'h1,
    F_AND = 4'h2,
    F_XOR = 4'h3
  } ifun_t;
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;
  localparam logic [63:0] STACK_DEC = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] STACK_INC = 64'd8;
  function automatic logic is_valid_op(input logic [3:0] icode, input logic [3:0] ifun);
    return icode == I_OPQ && ifun <= F_XOR;
  endfunction
endpackage

// File: rtl/execute_alu_core.sv
// execute_alu_core: combinational y86 ALU producing result and zf/sf/of flags
module execute_alu_core
  import execute_alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] alu_a,
  input  logic [W-1:0] alu_b,
  input  logic [3:0]   ifun,
  input  logic [3:0]   icode,
  output logic [W-1:0] val_e,
  output logic         zf,
  output logic         sf,
  output logic         of
);
  logic [W-1:0] sum, diff;
  logic add_of, sub_of, is_op;
  always_comb begin
    sum = alu_b + alu_a;
    diff = alu_b - alu_a;
    is_op = icode == I_OPQ;
    val_e = !is_op ? sum :
            ifun == F_ADD ? sum :
            ifun == F_SUB ? diff :
            ifun == F_AND ? (alu_b & alu_a) :
            ifun == F_XOR ? (alu_b ^ alu_a) : '0;
    add_of = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
    sub_of = (alu_b[W-1] != alu_a[W-1]) && (diff[W-1] != alu_b[W-1]);
    zf = val_e == '0;
    sf = val_e[W-1];
    of = (is_op && ifun == F_SUB) ? sub_of : (!is_op || ifun == F_ADD) ? add_of : 1'b0;
  end
endmodule

// File: rtl/execute_alu.sv
// execute_alu: y86 execute stage operand select, ALU and registered condition codes
module execute_alu
  import execute_alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic         set_cc,
  output logic [W-1:0] alu_A,
  output logic [W-1:0] alu_B,
  output logic [W-1:0] e_valE,
  output logic [2:0]   CC
);
  logic zf, sf, of;
  always_comb begin
    alu_A = E_icode inside {I_RRMOVQ, I_OPQ} ? E_valA :
            E_icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ} ? E_valC :
            E_icode inside {I_CALL, I_PUSHQ} ? W'(STACK_DEC) :
            E_icode inside {I_RET, I_POPQ} ? W'(STACK_INC) : '0;
    alu_B = E_icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ} ? E_valB : '0;
  end
  execute_alu_core #(.W(W)) u_core (
    .alu_a(alu_A),
    .alu_b(alu_B),
    .ifun (E_ifun),
    .icode(E_icode),
    .val_e(e_valE),
    .zf   (zf),
    .sf   (sf),
    .of   (of)
  );
  always_ff @(posedge clk) begin
    if (rst) CC <= CC_RESET;
    else if (set_cc && is_valid_op(E_icode, E_ifun)) CC <= {zf, sf, of};
  end
endmodule

// File: tb/tb_execute_alu.sv
// tb_execute_alu: directed self-checking bench for execute_alu
module tb_execute_alu;
  logic        clk = 0;
  logic        rst;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        set_cc;
  logic [63:0] alu_A, alu_B, e_valE;
  logic [2:0]  CC;
  int n_cmp = 0;
  int n_err = 0;

  execute_alu #(.W(64)) dut (
    .clk(clk), .rst(rst), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .set_cc(set_cc),
    .alu_A(alu_A), .alu_B(alu_B), .e_valE(e_valE), .CC(CC)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic sc);
    E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c; set_cc = sc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    drive(4'h1, 4'h0, 64'h55, 64'h66, 64'h77, 1'b0);
    tick();
    check("reset_cc", {61'd0, CC}, 64'h4);
    check("nop_vale", e_valE, 64'h0);
    rst = 0;

    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1);
    check("add_ovf_vale", e_valE, 64'h8000_0000_0000_0000);
    check("add_ovf_alua", alu_A, 64'h7FFF_FFFF_FFFF_FFFF);
    check("add_ovf_alub", alu_B, 64'h1);
    check("add_cc_pre_edge", {61'd0, CC}, 64'h4);
    tick();
    check("add_ovf_cc", {61'd0, CC}, 64'h3);

    drive(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 1'b1);
    check("sub_zero_vale", e_valE, 64'h0);
    tick();
    check("sub_zero_cc", {61'd0, CC}, 64'h4);
    drive(4'h6, 4'h1, 64'h6, 64'h5, 64'h0, 1'b1);
    check("sub_neg_vale", e_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("sub_neg_cc", {61'd0, CC}, 64'h2);

    drive(4'h6, 4'h3, 64'hF0, 64'hF0, 64'h0, 1'b0);
    check("xor_vale", e_valE, 64'h0);
    tick();
    check("xor_nocc", {61'd0, CC}, 64'h2);

    drive(4'h4, 4'h0, 64'h0, 64'h20, 64'h10, 1'b1);
    check("rmmovq_vale", e_valE, 64'h30);
    tick();
    check("rmmovq_nocc", {61'd0, CC}, 64'h2);

    drive(4'h6, 4'h4, 64'h3, 64'h5, 64'h0, 1'b1);
    check("bad_ifun_vale", e_valE, 64'h0);
    tick();
    check("bad_ifun_nocc", {61'd0, CC}, 64'h2);

    drive(4'h6, 4'h2, 64'hF0, 64'h3C, 64'h0, 1'b1);
    check("and_vale", e_valE, 64'h30);
    tick();
    check("and_cc", {61'd0, CC}, 64'h0);

    drive(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 1'b1);
    check("sub_ovf_vale", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    tick();
    check("sub_ovf_cc", {61'd0, CC}, 64'h1);

    drive(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1);
    check("add_wrap_vale", e_valE, 64'h0);
    tick();
    check("add_wrap_cc", {61'd0, CC}, 64'h4);

    drive(4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 1'b0);
    check("pushq_vale", e_valE, 64'hF8);
    check("pushq_alua", alu_A, 64'hFFFF_FFFF_FFFF_FFF8);
    drive(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 1'b0);
    check("popq_vale", e_valE, 64'h108);
    drive(4'h8, 4'h0, 64'h0, 64'h100, 64'h0, 1'b0);
    check("call_vale", e_valE, 64'hF8);
    drive(4'h9, 4'h0, 64'h0, 64'h100, 64'h0, 1'b0);
    check("ret_vale", e_valE, 64'h108);

    drive(4'h3, 4'h0, 64'h0, 64'h999, 64'h1234, 1'b0);
    check("irmovq_vale", e_valE, 64'h1234);
    check("irmovq_alub", alu_B, 64'h0);
    drive(4'h2, 4'h0, 64'h7, 64'h99, 64'h0, 1'b0);
    check("rrmovq_vale", e_valE, 64'h7);
    drive(4'h5, 4'h0, 64'h0, 64'h20, 64'h8, 1'b0);
    check("mrmovq_vale", e_valE, 64'h28);
    drive(4'h0, 4'h0, 64'h11, 64'h22, 64'h33, 1'b0);
    check("halt_vale", e_valE, 64'h0);
    drive(4'h7, 4'h0, 64'h11, 64'h22, 64'h33, 1'b0);
    check("jxx_vale", e_valE, 64'h0);

    drive(4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 1'b1);
    tick();
    check("pre_rst_cc", {61'd0, CC}, 64'h2);
    rst = 1;
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1);
    check("rst_vale_live", e_valE, 64'h8000_0000_0000_0000);
    tick();
    check("rst_wins_cc", {61'd0, CC}, 64'h4);
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
